// File: rtl/membus_ram_responder.sv
// Slave end of the memory-side membus: a word RAM that answers every accepted request
// in order after a fixed LATENCY, with an optional post-reset zeroing sweep.
module membus_ram_responder #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 14,
  parameter int LATENCY    = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  membus_valid,
  output logic                  membus_ready,
  input  logic [ADDR_WIDTH-1:0] membus_addr,
  input  logic                  membus_wen,
  input  logic [DATA_WIDTH-1:0] membus_wdata,
  output logic                  membus_rvalid,
  output logic [DATA_WIDTH-1:0] membus_rdata,
  output logic                  init_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("membus_ram_responder: LATENCY must be in 1..4");
    end
    if (DEPTH_LOG2 > ADDR_WIDTH) begin : g_bad_depth
      $error("membus_ram_responder: DEPTH_LOG2 must not exceed ADDR_WIDTH");
    end
  endgenerate

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    init_done_q, init_done_d;
  logic [LATENCY-1:0]      pipe_valid_q, pipe_valid_d;
  logic [DATA_WIDTH-1:0]   pipe_data_q [LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_data_d [LATENCY];

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic                    accept;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    unused_addr;

  // Upper address bits are deliberately ignored so accesses alias modulo depth.
  assign unused_addr   = ^membus_addr;
  assign idx           = membus_addr[DEPTH_LOG2-1:0];
  assign membus_ready  = (state_q == ST_IDLE) && !rst;
  assign accept        = membus_valid && membus_ready;
  assign membus_rvalid = pipe_valid_q[LATENCY-1];
  assign membus_rdata  = pipe_data_q[LATENCY-1];
  assign init_done     = init_done_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    init_done_d  = init_done_q;
    mem_we       = 1'b0;
    mem_waddr    = idx;
    mem_wdata    = membus_wdata;

    case (state_q)
      ST_INIT: begin
        mem_we    = !rst;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      default: begin
        mem_we = accept && membus_wen;
      end
    endcase

    // Stage 0 captures the response value; reads see every write from earlier edges.
    pipe_valid_d[0] = accept;
    pipe_data_d[0]  = accept ? (membus_wen ? membus_wdata : mem[idx]) : pipe_data_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      // Data only advances with a valid entry, so rdata holds between responses.
      pipe_data_d[i]  = pipe_valid_q[i-1] ? pipe_data_q[i-1] : pipe_data_q[i];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
      clr_cnt_q    <= '0;
      init_done_q  <= 1'(INIT_CLEAR == 0);
      pipe_valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      init_done_q  <= init_done_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
    end
  end

  // NOTE: the RAM array has no reset; clearing is the job of the INIT sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_membus_ram_responder.sv
// Bench for membus_ram_responder: three instances with different LATENCY/INIT_CLEAR,
// a transaction-level reference model, a per-cycle compare process and literal checks.
module tb_membus_ram_responder;

  localparam int NI     = 3;
  localparam int LAT [NI] = '{1, 3, 2};
  localparam int ICL [NI] = '{1, 1, 0};
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst_s    [NI];
  logic        valid_s  [NI];
  logic        wen_s    [NI];
  logic [19:0] addr_s   [NI];
  logic [31:0] wdata_s  [NI];
  logic        ready_s  [NI];
  logic        rvalid_s [NI];
  logic [31:0] rdata_s  [NI];
  logic        done_s   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    membus_ram_responder #(
      .ADDR_WIDTH(20), .DATA_WIDTH(32), .DEPTH_LOG2(4),
      .LATENCY(LAT[g]), .INIT_CLEAR(ICL[g])
    ) u_dut (
      .clk          (clk),
      .rst          (rst_s[g]),
      .membus_valid (valid_s[g]),
      .membus_ready (ready_s[g]),
      .membus_addr  (addr_s[g]),
      .membus_wen   (wen_s[g]),
      .membus_wdata (wdata_s[g]),
      .membus_rvalid(rvalid_s[g]),
      .membus_rdata (rdata_s[g]),
      .init_done    (done_s[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, k, act, exp);
    end
  endtask

  // Reference model: words per instance, a queue of due responses, an init countdown.
  typedef struct {
    int          k;
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m     [NI][DEPTH];
  int          init_left [NI];
  bit          seen      [NI];
  logic [31:0] last_data [NI];
  int          cyc = 0;

  logic [31:0] log_data [NI][64];
  int          log_cyc  [NI][64];
  int          log_n    [NI];

  initial begin
    for (int k = 0; k < NI; k++) begin
      seen[k] = 0; init_left[k] = 0; log_n[k] = 0; last_data[k] = '0;
      for (int w = 0; w < DEPTH; w++) mem_m[k][w] = '0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (rst_s[k] === 1'b1) begin
        seen[k]      = 1;
        init_left[k] = (ICL[k] != 0) ? DEPTH : 0;
        last_data[k] = '0;
        if (ICL[k] != 0)
          for (int w = 0; w < DEPTH; w++) mem_m[k][w] = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].k == k) exp_q.delete(i);
      end else if (seen[k]) begin
        if (init_left[k] > 0) begin
          init_left[k]--;
        end else if (valid_s[k] === 1'b1) begin
          exp_t e;
          e.k    = k;
          e.due  = cyc + LAT[k] - 1;
          e.data = wen_s[k] ? wdata_s[k] : mem_m[k][addr_s[k][3:0]];
          if (wen_s[k]) mem_m[k][addr_s[k][3:0]] = wdata_s[k];
          exp_q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (seen[k]) begin
        int  fi;
        bit  exp_rv;
        fi = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (exp_q[i].k == k) begin fi = i; break; end
        exp_rv = (fi >= 0) && (exp_q[fi].due == cyc);
        check("ready", k, ready_s[k], (rst_s[k] !== 1'b1) && (init_left[k] == 0));
        check("init_done", k, done_s[k], (init_left[k] == 0));
        check("rvalid", k, rvalid_s[k], exp_rv);
        if (exp_rv) begin
          last_data[k] = exp_q[fi].data;
          exp_q.delete(fi);
        end
        check("rdata", k, rdata_s[k], last_data[k]);
        if (rvalid_s[k] === 1'b1 && log_n[k] < 64) begin
          log_data[k][log_n[k]] = rdata_s[k];
          log_cyc[k][log_n[k]]  = cyc;
          log_n[k]++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int k, input bit w, input logic [19:0] a, input logic [31:0] d);
    valid_s[k] = 1'b1; wen_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
    tick(1);
    valid_s[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lo, n0, base;

    for (int k = 0; k < NI; k++) begin
      rst_s[k] = 1'b1; valid_s[k] = 1'b0; wen_s[k] = 1'b0;
      addr_s[k] = '0; wdata_s[k] = '0;
    end
    tick(3);
    check("rst_rdata", 0, rdata_s[0], 32'h0);
    check("rst_ready", 2, ready_s[2], 1'b0);
    for (int k = 0; k < NI; k++) rst_s[k] = 1'b0;

    // Instance 0: hammer valid with random writes through INIT; none may land.
    lo = 0;
    while (ready_s[0] !== 1'b1 && lo < 100) begin
      valid_s[0] = 1'b1; wen_s[0] = 1'b1;
      addr_s[0] = 20'($urandom); wdata_s[0] = $urandom;
      tick(1);
      lo++;
    end
    check("init_ready_low_cycles", 0, lo, 16);
    check("init_done_at_ready", 0, done_s[0], 1'b1);
    n0 = cyc + 1;
    drive(0, 1'b1, 20'h7, 32'hCAFEF00D);
    tick(3);
    check("init_no_early_resp", 0, log_n[0], 1);
    check("first_accept_data", 0, log_data[0][0], 32'hCAFEF00D);
    check("first_accept_cycle", 0, log_cyc[0][0], n0);

    drive(0, 1'b0, 20'h5, 32'h0);
    tick(3);
    check("cleared_word5", 0, log_data[0][1], 32'h0);

    n0 = cyc + 1;
    drive(0, 1'b1, 20'h10, 32'hDEADBEEF);
    drive(0, 1'b0, 20'h10, 32'h0);
    tick(3);
    check("wr_resp", 0, log_data[0][2], 32'hDEADBEEF);
    check("wr_resp_cycle", 0, log_cyc[0][2], n0);
    check("rd_after_wr", 0, log_data[0][3], 32'hDEADBEEF);
    check("rd_after_wr_cycle", 0, log_cyc[0][3], n0 + 1);

    drive(0, 1'b1, 20'h00013, 32'h1234);
    drive(0, 1'b0, 20'h00003, 32'h0);
    tick(3);
    check("alias_read", 0, log_data[0][5], 32'h1234);

    // Instance 1 (LATENCY=3): preload then four back-to-back reads.
    for (int i = 0; i < 4; i++) drive(1, 1'b1, 20'(i), 32'hA0 + 32'(i));
    tick(4);
    base = log_n[1];
    n0   = cyc + 1;
    for (int i = 0; i < 4; i++) drive(1, 1'b0, 20'(i), 32'h0);
    tick(6);
    check("lat3_count", 1, log_n[1] - base, 4);
    check("lat3_first_cycle", 1, log_cyc[1][base], n0 + 2);
    for (int i = 0; i < 4; i++) begin
      check("lat3_data", 1, log_data[1][base+i], 32'hA0 + 32'(i));
      check("lat3_consecutive", 1, log_cyc[1][base+i], n0 + 2 + i);
    end

    // Instance 2 (LATENCY=2, no clear): reset drops an in-flight read, RAM survives.
    drive(2, 1'b1, 20'h9, 32'h55AA);
    tick(4);
    base = log_n[2];
    drive(2, 1'b0, 20'h9, 32'h0);
    rst_s[2] = 1'b1;
    tick(2);
    rst_s[2] = 1'b0;
    tick(5);
    check("flushed_no_resp", 2, log_n[2] - base, 0);
    drive(2, 1'b0, 20'h9, 32'h0);
    tick(4);
    check("kept_after_rst_count", 2, log_n[2] - base, 1);
    check("kept_after_rst_data", 2, log_data[2][base], 32'h55AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
